// File: rtl/route_equiv_checker_if.sv
// Bundle of run-control, DUT-drive and status signals between route_equiv_checker
// and its environment. Capture outputs exist only when CMP_CAPTURE_EN is defined.
interface route_equiv_checker_if #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 32,
    parameter int MCNT_W = 16
);
    // start is a single-cycle request with no ready: it is taken on any edge where
    // the checker is not busy (IDLE or DONE) and silently dropped otherwise.
    logic              start;
    logic [OUT_W-1:0]  golden_out;
    logic [OUT_W-1:0]  netlist_out;
    logic [IN_W-1:0]   stim;
    logic              dut_rst;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MCNT_W-1:0] mismatch_cnt;
    logic [31:0]       vector_cnt;
    logic [1:0]        state_dbg;
`ifdef CMP_CAPTURE_EN
    logic              fail_valid;
    logic [OUT_W-1:0]  fail_golden;
    logic [OUT_W-1:0]  fail_netlist;
    logic [31:0]       fail_idx;
`endif

    modport master (
        input  start, golden_out, netlist_out,
`ifdef CMP_CAPTURE_EN
        output fail_valid, fail_golden, fail_netlist, fail_idx,
`endif
        output stim, dut_rst, busy, done, pass, mismatch_cnt, vector_cnt, state_dbg
    );

    modport slave (
        output start, golden_out, netlist_out,
`ifdef CMP_CAPTURE_EN
        input  fail_valid, fail_golden, fail_netlist, fail_idx,
`endif
        input  stim, dut_rst, busy, done, pass, mismatch_cnt, vector_cnt, state_dbg
    );
endinterface

// File: rtl/route_equiv_checker.sv
// Golden-vs-routed equivalence engine: resets both DUT copies, drives LFSR vectors,
// counts output mismatches. Define CMP_CAPTURE_EN to latch the first failing compare.
module route_equiv_checker #(
    parameter int          IN_W    = 8,
    parameter int          OUT_W   = 32,
    parameter int          NUM_VEC = 1000,
    parameter int          SETTLE  = 2,
    parameter int          RST_CYC = 2,
    parameter logic [31:0] SEED    = 32'h1,
    parameter int          MCNT_W  = 16
) (
    input logic clk,
    input logic rst,
    route_equiv_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, APPLY = 2'd2, DONE = 2'd3} state_t;

    localparam logic [31:0] SEED_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] POLY      = 32'h8020_0003;

    state_t            state, state_next;
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_next;
    logic [31:0]       cyc;
    logic              first_load;
    logic [IN_W-1:0]   stim_q;
    logic              dut_rst_q;
    logic [MCNT_W-1:0] mcnt;
    logic [31:0]       vcnt;

    logic accept, rst_cmp, vec_cmp, load, miss;

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'h0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // After the reset check there is one release cycle (dut_rst low, stim still 0)
    // before the first vector is loaded; first_load marks that cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        rst_cmp    = 1'b0;
        vec_cmp    = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = INIT;
                end
            end
            INIT: begin
                if (cyc == 32'(RST_CYC - 1)) begin
                    rst_cmp    = 1'b1;
                    state_next = APPLY;
                end
            end
            APPLY: begin
                if (first_load) begin
                    load = 1'b1;
                end else if (cyc == 32'(SETTLE - 1)) begin
                    vec_cmp = 1'b1;
                    if (vcnt == 32'(NUM_VEC - 1)) state_next = DONE;
                    else                          load       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign miss = (rst_cmp || vec_cmp) && (bus.golden_out != bus.netlist_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= SEED_INIT;
            cyc        <= 32'h0;
            first_load <= 1'b0;
            stim_q     <= '0;
            dut_rst_q  <= 1'b1;
            mcnt       <= '0;
            vcnt       <= 32'h0;
        end else begin
            if (accept) begin
                lfsr       <= SEED_INIT;
                cyc        <= 32'h0;
                first_load <= 1'b0;
                stim_q     <= '0;
                dut_rst_q  <= 1'b1;
                mcnt       <= '0;
                vcnt       <= 32'h0;
            end
            if (state == INIT) begin
                cyc <= cyc + 32'h1;
                if (rst_cmp) begin
                    cyc        <= 32'h0;
                    dut_rst_q  <= 1'b0;
                    first_load <= 1'b1;
                end
            end
            if (state == APPLY) begin
                cyc <= cyc + 32'h1;
                if (load) begin
                    lfsr       <= lfsr_next;
                    stim_q     <= lfsr_next[IN_W-1:0];
                    cyc        <= 32'h0;
                    first_load <= 1'b0;
                end
                if (vec_cmp) vcnt <= vcnt + 32'h1;
            end
            if (miss && (mcnt != {MCNT_W{1'b1}})) mcnt <= mcnt + 1'b1;
        end
    end

`ifdef CMP_CAPTURE_EN
    logic             cap_valid;
    logic [OUT_W-1:0] cap_golden;
    logic [OUT_W-1:0] cap_netlist;
    logic [31:0]      cap_idx;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cap_valid   <= 1'b0;
            cap_golden  <= '0;
            cap_netlist <= '0;
            cap_idx     <= 32'h0;
        end else if (miss && !cap_valid) begin
            cap_valid   <= 1'b1;
            cap_golden  <= bus.golden_out;
            cap_netlist <= bus.netlist_out;
            cap_idx     <= vcnt;
        end
    end

    assign bus.fail_valid   = cap_valid;
    assign bus.fail_golden  = cap_golden;
    assign bus.fail_netlist = cap_netlist;
    assign bus.fail_idx     = cap_idx;
`endif

    assign bus.stim         = stim_q;
    assign bus.dut_rst      = dut_rst_q;
    assign bus.busy         = (state == INIT) || (state == APPLY);
    assign bus.done         = (state == DONE);
    assign bus.pass         = (state == DONE) && (mcnt == '0);
    assign bus.mismatch_cnt = mcnt;
    assign bus.vector_cnt   = vcnt;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_route_equiv_checker.sv
// Directed bench for route_equiv_checker: a short 4-vector instance and a 20-vector
// instance with a 4-bit saturating mismatch counter, both fed by a combinational DUT model.
module tb_route_equiv_checker;
    logic clk;
    logic rst;
    logic [31:0] flip_a;
    logic [31:0] flip_b;
    int n_checks;
    int n_errors;
    logic [7:0] stim_rec [0:63];
    logic       rst_rec  [0:63];

    route_equiv_checker_if #(.IN_W(8), .OUT_W(32), .MCNT_W(16)) ifa ();
    route_equiv_checker_if #(.IN_W(8), .OUT_W(32), .MCNT_W(4))  ifb ();

    route_equiv_checker #(.IN_W(8), .OUT_W(32), .NUM_VEC(4), .SETTLE(2), .RST_CYC(2),
                          .SEED(32'h1), .MCNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    route_equiv_checker #(.IN_W(8), .OUT_W(32), .NUM_VEC(20), .SETTLE(2), .RST_CYC(2),
                          .SEED(32'h0), .MCNT_W(4))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Combinational stand-in for the two DUT copies; flip_* corrupts the routed copy.
    assign ifa.golden_out  = ifa.dut_rst ? 32'h0 : {ifa.stim, ~ifa.stim, ifa.stim ^ 8'h5a, 8'h3c};
    assign ifa.netlist_out = ifa.golden_out ^ flip_a;
    assign ifb.golden_out  = ifb.dut_rst ? 32'h0 : {ifb.stim, ~ifb.stim, ifb.stim ^ 8'h5a, 8'h3c};
    assign ifb.netlist_out = ifb.golden_out ^ flip_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pulse start on dut_a; returns 1 time unit after the start edge.
    task automatic kick_a();
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
    endtask

    // Step edges after the start edge until done or limit; flips the routed copy in
    // [lo,hi) and re-pulses start at edge st_at. n = edges counted from the start edge.
    task automatic run_a(input int limit, input int lo, input int hi, input int st_at,
                         output int n);
        n = 0;
        flip_a = (lo <= 0 && hi > 0) ? 32'h1 : 32'h0;
        while (n < limit && !ifa.done) begin
            @(posedge clk);
            #1;
            n++;
            if (n < 64) begin
                stim_rec[n] = ifa.stim;
                rst_rec[n]  = ifa.dut_rst;
            end
            flip_a    = (n >= lo && n < hi) ? 32'h1 : 32'h0;
            ifa.start = (n == st_at);
        end
        flip_a    = 32'h0;
        ifa.start = 1'b0;
    endtask

    initial begin
        int n;
        n_checks  = 0;
        n_errors  = 0;
        flip_a    = 32'h0;
        flip_b    = 32'hffff_ffff;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_state", 64'(ifa.state_dbg), 64'd0);
        check("rst_stim", 64'(ifa.stim), 64'd0);
        check("rst_dut_rst", 64'(ifa.dut_rst), 64'd1);
        check("rst_flags", {61'd0, ifa.busy, ifa.done, ifa.pass}, 64'd0);
        check("rst_cnts", {ifa.vector_cnt, 16'd0, ifa.mismatch_cnt}, 64'd0);

        // Clean run: 1 + 2 + 4*2 = 11 edges, first two vectors 03, 02.
        kick_a();
        check("init_entry", {ifa.state_dbg, ifa.dut_rst, ifa.busy, ifa.stim}, {54'd0, 2'd1, 1'b1, 1'b1, 8'h00});
        run_a(200, 100, 100, -1, n);
        check("clean_latency", 64'(n), 64'd11);
        check("clean_rst_hold", {rst_rec[1], rst_rec[2]}, 64'b10);
        check("clean_stim_v1", 64'(stim_rec[3]), 64'h03);
        check("clean_stim_v2", 64'(stim_rec[5]), 64'h02);
        check("clean_stim_v3", 64'(stim_rec[7]), 64'h01);
        check("clean_stim_last", 64'(ifa.stim), 64'h03);
        check("clean_pass", {ifa.busy, ifa.done, ifa.pass}, 64'b011);
        check("clean_mcnt", 64'(ifa.mismatch_cnt), 64'd0);
        check("clean_vcnt", 64'(ifa.vector_cnt), 64'd4);
`ifdef CMP_CAPTURE_EN
        check("clean_cap_valid", 64'(ifa.fail_valid), 64'd0);
`endif

        // Restart from DONE, vector 2 (held edges 5..7) corrupted in bit 0.
        kick_a();
        check("restart_clear", {ifa.vector_cnt, 16'd0, ifa.mismatch_cnt}, 64'd0);
        run_a(200, 5, 7, -1, n);
        check("flip_latency", 64'(n), 64'd11);
        check("flip_stim_v1", 64'(stim_rec[3]), 64'h03);
        check("flip_stim_v2", 64'(stim_rec[5]), 64'h02);
        check("flip_mcnt", 64'(ifa.mismatch_cnt), 64'd1);
        check("flip_pass", {ifa.done, ifa.pass}, 64'b10);
        check("flip_vcnt", 64'(ifa.vector_cnt), 64'd4);
`ifdef CMP_CAPTURE_EN
        check("flip_cap_valid", 64'(ifa.fail_valid), 64'd1);
        check("flip_cap_idx", 64'(ifa.fail_idx), 64'd1);
        check("flip_cap_xor", 64'(ifa.fail_golden ^ ifa.fail_netlist), 64'd1);
`endif

        // start pulsed at edge 5 (a compare edge) while busy must be ignored.
        kick_a();
        run_a(200, 100, 100, 4, n);
        check("busy_start_latency", 64'(n), 64'd11);
        check("busy_start_result", {ifa.vector_cnt, 15'd0, ifa.pass, ifa.mismatch_cnt}, {32'd4, 15'd0, 1'b1, 16'd0});

        // Mid-APPLY reset with a corrupted routed copy, then a clean full run.
        kick_a();
        run_a(6, 0, 100, -1, n);
        check("mid_mcnt", 64'(ifa.mismatch_cnt), 64'd2);
        check("mid_vcnt", 64'(ifa.vector_cnt), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_state", {ifa.state_dbg, ifa.dut_rst, ifa.busy, ifa.stim}, {54'd0, 2'd0, 1'b1, 1'b0, 8'h00});
        check("midrst_cnts", {ifa.vector_cnt, 16'd0, ifa.mismatch_cnt}, 64'd0);
        kick_a();
        run_a(200, 100, 100, -1, n);
        check("after_rst_latency", 64'(n), 64'd11);
        check("after_rst_result", {ifa.vector_cnt, 15'd0, ifa.pass, ifa.mismatch_cnt}, {32'd4, 15'd0, 1'b1, 16'd0});

        // Always-inverted routed copy: 21 mismatches saturate a 4-bit counter at 15.
        ifb.start = 1'b1;
        @(posedge clk);
        #1;
        ifb.start = 1'b0;
        n = 0;
        while (n < 200 && !ifb.done) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sat_latency", 64'(n), 64'd43);
        check("sat_mcnt", 64'(ifb.mismatch_cnt), 64'd15);
        check("sat_vcnt", 64'(ifb.vector_cnt), 64'd20);
        check("sat_pass", {ifb.done, ifb.pass}, 64'b10);
`ifdef CMP_CAPTURE_EN
        check("sat_cap_idx", {31'd0, ifb.fail_valid, ifb.fail_idx}, {31'd0, 1'b1, 32'd0});
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
